// File: rtl/seg_scan.sv
// Binary-to-BCD display stage: sequential double-dabble conversion feeding a
// time-multiplexed, active-low 4-digit common-anode 7-segment driver.
module seg_scan #(
  parameter int width    = 4,
  parameter int scan_div = 50000,
  parameter bit blank_lz = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [width-1:0] cnt_in,
  output logic [7:0]       seg,
  output logic [3:0]       sel,
  output logic [15:0]      bcd,
  output logic             bcd_vld
);

  localparam int               div_w     = $clog2(scan_div);
  localparam logic [div_w-1:0] div_last  = div_w'(scan_div - 1);
  localparam logic [3:0]       iter_last = 4'(width - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               start_s;
  logic               first_r;
  logic [width-1:0]   bin_r, last_r;
  logic [15:0]        acc_r, adj_s, disp_r;
  logic [3:0]         iter_r;
  logic               vld_r;
  logic [div_w-1:0]   div_r;
  logic [1:0]         idx_r;
  logic [3:0]         nib_s;
  logic               blank_s;
  logic [7:0]         seg_r;
  logic [3:0]         sel_r;

  function automatic logic [15:0] dabble_adj(input logic [15:0] v);
    logic [15:0] r;
    r = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = (v[k*4 +: 4] >= 4'd5) ? (v[k*4 +: 4] + 4'd3) : v[k*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hBF;
    endcase
    return p;
  endfunction

  // Conversion FSM next-state; a forced first conversion runs after reset
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    adj_s   = dabble_adj(acc_r);
    case (state_r)
      IDLE: begin
        if (first_r || (cnt_in != last_r)) begin
          start_s = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (iter_r == iter_last) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Double-dabble datapath; the display register only changes in DONE
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      first_r <= 1'b1;
      bin_r   <= {width{1'b0}};
      last_r  <= {width{1'b0}};
      acc_r   <= 16'h0000;
      iter_r  <= 4'd0;
      disp_r  <= 16'h0000;
      vld_r   <= 1'b0;
    end else begin
      vld_r <= 1'b0;
      if (start_s) begin
        bin_r   <= cnt_in;
        last_r  <= cnt_in;
        acc_r   <= 16'h0000;
        iter_r  <= 4'd0;
        first_r <= 1'b0;
      end else if (state_r == SHIFT) begin
        acc_r  <= {adj_s[14:0], bin_r[width-1]};
        bin_r  <= bin_r << 1'b1;
        iter_r <= iter_r + 4'd1;
      end else if (state_r == DONE) begin
        disp_r <= acc_r;
        vld_r  <= 1'b1;
      end
    end
  end

  // Scan divider and digit index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_r <= {div_w{1'b0}};
      idx_r <= 2'd0;
    end else if (div_r == div_last) begin
      div_r <= {div_w{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      div_r <= div_r + div_w'(1);
    end
  end

  // Digit select and leading-zero blanking (ones digit is never blanked)
  always_comb begin
    nib_s   = 4'h0;
    blank_s = 1'b0;
    case (idx_r)
      2'd0: begin
        nib_s   = disp_r[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        nib_s   = disp_r[7:4];
        blank_s = blank_lz && (disp_r[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s   = disp_r[11:8];
        blank_s = blank_lz && (disp_r[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s   = disp_r[15:12];
        blank_s = blank_lz && (disp_r[15:12] == 4'h0);
      end
      default: begin
        nib_s   = 4'h0;
        blank_s = 1'b0;
      end
    endcase
  end

  // Registered segment/select outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_r <= 8'hFF;
      sel_r <= 4'hF;
    end else begin
      seg_r <= blank_s ? 8'hFF : seg_decode(nib_s);
      sel_r <= ~(4'b0001 << idx_r);
    end
  end

  assign seg     = seg_r;
  assign sel     = sel_r;
  assign bcd     = disp_r;
  assign bcd_vld = vld_r;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: three instances cover width 4/13/8 and both
// blanking modes, sharing one clock and reset.
module tb_seg_scan;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  cnt_a;
  logic [12:0] cnt_b;
  logic [7:0]  cnt_c;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic [15:0] bcd_a, bcd_b, bcd_c;
  logic        vld_a, vld_b, vld_c;

  int checks = 0;
  int errors = 0;
  int bad_a  = 0;
  logic [7:0] digs_a [4];
  logic [7:0] digs_b [4];
  logic [7:0] digs_c [4];

  seg_scan #(.width(4), .scan_div(4), .blank_lz(1'b1)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_in(cnt_a),
    .seg(seg_a), .sel(sel_a), .bcd(bcd_a), .bcd_vld(vld_a));

  seg_scan #(.width(13), .scan_div(4), .blank_lz(1'b0)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_in(cnt_b),
    .seg(seg_b), .sel(sel_b), .bcd(bcd_b), .bcd_vld(vld_b));

  seg_scan #(.width(8), .scan_div(4), .blank_lz(1'b1)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_in(cnt_c),
    .seg(seg_c), .sel(sel_c), .bcd(bcd_c), .bcd_vld(vld_c));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int sel_idx(input logic [3:0] s);
    case (s)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit legal_seg(input logic [7:0] s);
    case (s)
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
      8'h82, 8'hF8, 8'h80, 8'h90, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Track the latest pattern shown on each digit position
  always @(negedge sys_clk) begin
    if (sel_idx(sel_a) >= 0) begin
      digs_a[sel_idx(sel_a)] = seg_a;
      if (!legal_seg(seg_a)) bad_a = bad_a + 1;
    end
    if (sel_idx(sel_b) >= 0) digs_b[sel_idx(sel_b)] = seg_b;
    if (sel_idx(sel_c) >= 0) digs_c[sel_idx(sel_c)] = seg_c;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Edges counted from the stimulus change: capture edge + width+1
  task automatic wait_vld(input int which, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge sys_clk);
      #1;
      if ((which == 0 && vld_a) || (which == 1 && vld_b) || (which == 2 && vld_c)) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int nvld;
    int first_vld;
    logic [3:0]  sel_hist [17];
    logic [15:0] first_bcd;

    sys_rst_n = 1'b0;
    cnt_a = 4'd0;
    cnt_b = 13'd0;
    cnt_c = 8'd0;
    tick(3);
    chk("rst_seg", seg_a, 8'hFF);
    chk("rst_sel", sel_a, 4'hF);
    chk("rst_bcd", bcd_a, 16'h0000);
    chk("rst_vld", vld_a, 1'b0);

    // Test 1: forced first conversion of 0 and the scan sequence
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nvld = 0;
    first_vld = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge sys_clk);
      #1;
      sel_hist[i] = sel_a;
      if (vld_a) begin
        nvld++;
        if (first_vld < 0) first_vld = i;
      end
    end
    chk("t1_vld_count", nvld, 1);
    chk("t1_vld_edge", first_vld, 6);
    chk("t1_bcd", bcd_a, 16'h0000);
    chk("t1_sel0", sel_hist[1], 4'b1110);
    chk("t1_sel0_end", sel_hist[4], 4'b1110);
    chk("t1_sel1", sel_hist[5], 4'b1101);
    chk("t1_sel2", sel_hist[9], 4'b1011);
    chk("t1_sel3", sel_hist[13], 4'b0111);
    tick(8);
    chk("t1_dig0", digs_a[0], 8'hC0);
    chk("t1_dig1", digs_a[1], 8'hFF);
    chk("t1_dig2", digs_a[2], 8'hFF);
    chk("t1_dig3", digs_a[3], 8'hFF);

    // Test 2: step 1..15 at 64-clock spacing
    for (int v = 1; v <= 15; v++) begin
      cnt_a = 4'(v);
      wait_vld(0, lat);
      chk($sformatf("t2_lat_%0d", v), lat, 6);
      chk($sformatf("t2_bcd_%0d", v), bcd_a, to_bcd(v));
      if (v == 15) begin
        tick(1);
        chk("t2_vld_one_cycle", vld_a, 1'b0);
        tick(63 - lat);
      end else begin
        tick(64 - lat);
      end
    end
    chk("t2_dig0", digs_a[0], 8'h92);
    chk("t2_dig1", digs_a[1], 8'hF9);
    chk("t2_dig2", digs_a[2], 8'hFF);
    chk("t2_dig3", digs_a[3], 8'hFF);

    // Test 3: widest input, no blanking
    cnt_b = 13'd8191;
    wait_vld(1, lat);
    chk("t3_lat", lat, 15);
    chk("t3_bcd", bcd_b, 16'h8191);
    tick(20);
    chk("t3_dig3", digs_b[3], 8'h80);
    chk("t3_dig2", digs_b[2], 8'hF9);
    chk("t3_dig1", digs_b[1], 8'h90);
    chk("t3_dig0", digs_b[0], 8'hF9);

    // Test 4: input churns during SHIFT, then settles on 9
    cnt_a = 4'd3;
    nvld = 0;
    first_bcd = 16'hFFFF;
    for (int i = 1; i <= 30; i++) begin
      @(posedge sys_clk);
      #1;
      if (vld_a) begin
        nvld++;
        if (nvld == 1) first_bcd = bcd_a;
      end
      if (i <= 6) cnt_a = 4'(3 + i);
    end
    chk("t4_vld_count", nvld, 2);
    chk("t4_inflight_bcd", first_bcd, 16'h0003);
    chk("t4_final_bcd", bcd_a, 16'h0009);
    tick(20);
    chk("t4_dig0", digs_a[0], 8'h90);
    chk("t4_dig1", digs_a[1], 8'hFF);
    chk("t4_legal_seg", bad_a, 0);

    // Test 5: asynchronous reset mid-SHIFT
    cnt_a = 4'd12;
    tick(3);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_seg", seg_a, 8'hFF);
    chk("t5_rst_sel", sel_a, 4'hF);
    chk("t5_rst_bcd", bcd_a, 16'h0000);
    chk("t5_rst_vld", vld_a, 1'b0);
    tick(2);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_vld(0, lat);
    chk("t5_lat", lat, 6);
    chk("t5_bcd", bcd_a, 16'h0012);

    // Test 6: embedded zero stays visible with blanking on
    tick(10);
    cnt_c = 8'd105;
    wait_vld(2, lat);
    chk("t6_lat", lat, 10);
    chk("t6_bcd", bcd_c, 16'h0105);
    tick(20);
    chk("t6_dig3", digs_c[3], 8'hFF);
    chk("t6_dig2", digs_c[2], 8'hF9);
    chk("t6_dig1", digs_c[1], 8'hC0);
    chk("t6_dig0", digs_c[0], 8'h92);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
